// File: rtl/programmer_spi_master.sv
// SPI mode-00 sequencer that shifts a configuration word into the on-chip programmer,
// and also drives the programmer's DRESET (CS & SCLK high) and HO (CS & SDI) side-band decodes.
module programmer_spi_master #(
    parameter int NUM_BITS      = 104,
    parameter int CLK_DIV       = 2,
    parameter int DRESET_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [NUM_BITS-1:0] data_in,
    input  logic                dreset_req,
    input  logic                ho_level,
    output logic                busy,
    output logic                done,
    output logic                SDI,
    output logic                SCLK,
    output logic                CS,
    output logic [2:0]          state_dbg
);

    // Handshake: start / dreset_req are single-cycle requests, taken only in a cycle where busy=0;
    // busy rises the cycle after an accept and falls when the sequencer is back in IDLE.

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(NUM_BITS + 1);
    localparam int DRS_W = $clog2(DRESET_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [DRS_W-1:0] DRS_LOAD = DRS_W'(DRESET_CYCLES - 1);
    localparam logic [DRS_W-1:0] DRS_ONE  = DRS_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5,
        ST_DRST  = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DRS_W-1:0]    drst_cnt_q, drst_cnt_d;
    logic [NUM_BITS-1:0] shreg_q, shreg_d;
    logic [NUM_BITS-1:0] shreg_next;
    logic                cs_q, cs_d;
    logic                sclk_q, sclk_d;
    logic                sdi_q, sdi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                div_exp;

    assign div_exp    = (div_cnt_q == '0);
    assign shreg_next = shreg_q >> 1;

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        drst_cnt_d = drst_cnt_q;
        shreg_d    = shreg_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        sdi_d      = sdi_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cs_d   = 1'b1;
                sclk_d = 1'b0;
                sdi_d  = ho_level;
                if (start) begin
                    shreg_d   = data_in;
                    bit_cnt_d = '0;
                    div_cnt_d = DIV_LOAD;
                    cs_d      = 1'b0;
                    sdi_d     = data_in[0];
                    state_d   = ST_SETUP;
                end else if (dreset_req) begin
                    sdi_d      = 1'b0;
                    sclk_d     = 1'b1;
                    drst_cnt_d = DRS_LOAD;
                    state_d    = ST_DRST;
                end
            end

            ST_SETUP, ST_LOW: begin
                if (div_exp) begin
                    sclk_d    = 1'b1;
                    div_cnt_d = DIV_LOAD;
                    state_d   = ST_HIGH;
                end else begin
                    div_cnt_d = div_cnt_q - DIV_ONE;
                end
            end

            ST_HIGH: begin
                if (div_exp) begin
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                    div_cnt_d = DIV_LOAD;
                    // Next bit is presented on the falling edge so it has a full low phase of setup.
                    if (bit_cnt_q == BIT_LAST) begin
                        sdi_d   = 1'b0;
                        state_d = ST_HOLD;
                    end else begin
                        shreg_d = shreg_next;
                        sdi_d   = shreg_next[0];
                        state_d = ST_LOW;
                    end
                end else begin
                    div_cnt_d = div_cnt_q - DIV_ONE;
                end
            end

            ST_HOLD: begin
                if (div_exp) begin
                    cs_d      = 1'b1;
                    done_d    = 1'b1;
                    div_cnt_d = DIV_LOAD;
                    state_d   = ST_GAP;
                end else begin
                    div_cnt_d = div_cnt_q - DIV_ONE;
                end
            end

            ST_GAP: begin
                if (div_exp) begin
                    state_d = ST_IDLE;
                end else begin
                    div_cnt_d = div_cnt_q - DIV_ONE;
                end
            end

            ST_DRST: begin
                if (drst_cnt_q == '0) begin
                    sclk_d    = 1'b0;
                    div_cnt_d = DIV_LOAD;
                    state_d   = ST_GAP;
                end else begin
                    drst_cnt_d = drst_cnt_q - DRS_ONE;
                end
            end

            default: begin
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                sdi_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            drst_cnt_q <= '0;
            shreg_q    <= '0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            sdi_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            drst_cnt_q <= drst_cnt_d;
            shreg_q    <= shreg_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            sdi_q      <= sdi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign SDI       = sdi_q;
    assign SCLK      = sclk_q;
    assign CS        = cs_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_programmer_spi_master.sv
// Bench for programmer_spi_master: a behavioural programmer model samples the pins,
// and committed words are checked against an expected-word queue.
module tb_programmer_spi_master;

  localparam int NB       = 104;
  localparam int DIV      = 2;
  localparam int DRC      = 4;
  localparam int CS_LOW   = DIV * (2 * NB + 1);
  localparam int BUDGET   = 2000;

  logic          clk;
  logic          reset;
  logic          start;
  logic [NB-1:0] data_in;
  logic          dreset_req;
  logic          ho_level;
  logic          busy;
  logic          done;
  logic          sdi;
  logic          sclk;
  logic          cs;
  logic [2:0]    state_dbg;

  programmer_spi_master #(
    .NUM_BITS      (NB),
    .CLK_DIV       (DIV),
    .DRESET_CYCLES (DRC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data_in    (data_in),
    .dreset_req (dreset_req),
    .ho_level   (ho_level),
    .busy       (busy),
    .done       (done),
    .SDI        (sdi),
    .SCLK       (sclk),
    .CS         (cs),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / report ----------------
  logic [NB-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- programmer model / pin monitor ----------------
  logic [NB-1:0] model_sr   = '0;
  logic [NB-1:0] prog_data  = '0;
  int rise_cnt      = 0;
  int cs_low_cnt    = 0;
  int busy_total    = 0;
  int done_total    = 0;
  int drst_hi_total = 0;
  int viol_total    = 0;
  int cs_fall_total = 0;
  int commit_total  = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_sdi = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      model_sr   = '0;
      rise_cnt   = 0;
      cs_low_cnt = 0;
    end else begin
      if (busy) busy_total++;
      if (done) done_total++;
      if (cs && sclk) drst_hi_total++;
      if (cs && busy && sdi) viol_total++;
      if (sclk && prev_sclk && (sdi != prev_sdi)) viol_total++;
      if (!cs && rise_cnt == NB && !sclk && sdi) viol_total++;
      if (!cs && prev_cs) cs_fall_total++;
      if (!cs) cs_low_cnt++;
      if (!cs && sclk && !prev_sclk) begin
        model_sr = {sdi, model_sr[NB-1:1]};
        rise_cnt++;
      end
      if (cs && !prev_cs) begin
        prog_data = model_sr;
        check("cs_rise_sclk_low", sclk, 0);
        check("cs_low_cycles", cs_low_cnt, CS_LOW);
        check("sclk_rises", rise_cnt, NB);
        check("done_at_cs_rise", done, 1);
        if (exp_q.size() == 0) check("unexpected_commit", 1, 0);
        else check("prog_data", prog_data, exp_q.pop_front());
        commit_total++;
        model_sr   = '0;
        rise_cnt   = 0;
        cs_low_cnt = 0;
      end
    end
    prev_cs   = cs;
    prev_sclk = sclk;
    prev_sdi  = sdi;
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [NB-1:0] d, input logic with_drst);
    @(negedge clk);
    start      = 1'b1;
    dreset_req = with_drst;
    data_in    = d;
    exp_q.push_back(d);
    @(negedge clk);
    start      = 1'b0;
    dreset_req = 1'b0;
    data_in    = ~d;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic wait_bits(input int b);
    int n = 0;
    while (rise_cnt < b && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("wait_bits_timeout", (rise_cnt >= b), 1);
  endtask

  task automatic run_frame(input logic [NB-1:0] d, input logic with_drst);
    int c0 = commit_total, d0 = done_total, h0 = drst_hi_total, v0 = viol_total;
    do_start(d, with_drst);
    wait_idle();
    check("frame_commits", commit_total - c0, 1);
    check("frame_done_pulses", done_total - d0, 1);
    check("frame_cs_and_sclk", drst_hi_total - h0, 0);
    check("frame_pin_viol", viol_total - v0, 0);
    check("frame_exp_q_empty", exp_q.size(), 0);
  endtask

  function automatic logic [NB-1:0] rand_word();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[NB-1:0];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [NB-1:0] w;
    int c0, d0, h0, b0, f0, v0;

    reset = 1'b0; start = 1'b0; dreset_req = 1'b0; ho_level = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    check("rst_cs", cs, 1);
    check("rst_sclk", sclk, 0);
    check("rst_sdi", sdi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(104'hA5_0123456789ABCDEF_FEDCBA98, 1'b0);
    run_frame({NB{1'b1}}, 1'b0);
    run_frame({NB{1'b0}}, 1'b0);

    // DRESET pulse
    c0 = commit_total; d0 = done_total; h0 = drst_hi_total; b0 = busy_total;
    f0 = cs_fall_total; v0 = viol_total;
    @(negedge clk); dreset_req = 1'b1;
    @(negedge clk); dreset_req = 1'b0;
    wait_idle();
    check("drst_hi_cycles", drst_hi_total - h0, DRC);
    check("drst_busy_cycles", busy_total - b0, DRC + DIV);
    check("drst_done", done_total - d0, 0);
    check("drst_cs_edges", cs_fall_total - f0, 0);
    check("drst_commits", commit_total - c0, 0);
    check("drst_sdi_viol", viol_total - v0, 0);

    // start wins over a simultaneous dreset_req
    run_frame(rand_word(), 1'b1);

    // start re-pulsed mid-frame is ignored
    w = rand_word();
    c0 = commit_total;
    do_start(w, 1'b0);
    wait_bits(40);
    @(negedge clk); start = 1'b1; data_in = rand_word();
    @(negedge clk); start = 1'b0;
    wait_idle();
    check("repulse_commits", commit_total - c0, 1);
    check("repulse_exp_q_empty", exp_q.size(), 0);

    // asynchronous reset mid-frame aborts without commit
    c0 = commit_total;
    do_start(rand_word(), 1'b0);
    wait_bits(50);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    check("midrst_cs", cs, 1);
    check("midrst_sclk", sclk, 0);
    check("midrst_sdi", sdi, 0);
    check("midrst_busy", busy, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_no_commit", commit_total - c0, 0);
    run_frame(rand_word(), 1'b0);

    // HO level in idle, data frame, then back to HO
    ho_level = 1'b1;
    repeat (3) @(negedge clk);
    check("ho_idle_sdi", sdi, 1);
    run_frame(rand_word(), 1'b0);
    repeat (3) @(negedge clk);
    check("ho_after_frame_sdi", sdi, 1);
    ho_level = 1'b0;
    repeat (3) @(negedge clk);
    check("ho_low_sdi", sdi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
